// File: rtl/arm_pipeline_ctrl_pkg.sv
// ============================================================================
// Module      : arm_pipeline_ctrl_pkg
// Description : Shared types and constants for the ARM pipeline stall/flush
//               controller: stall FSM states, register address width and the
//               program counter register index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arm_pipeline_ctrl_pkg;

  localparam int RegAddrWidth = 4;

  // R15 is the program counter in the ARM register file.
  localparam logic [RegAddrWidth-1:0] c_R15 = 4'd15;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_BUSY  = 2'd1,
    MEM_WAIT = 2'd2
  } t_Stall_State;

endpackage

`default_nettype wire

// File: rtl/arm_hazard_detect.sv
// ============================================================================
// Module      : arm_hazard_detect
// Description : Single-cycle hazard equations used while the pipeline runs
//               freely: load-use stall, pending PC write stall and the
//               Decode/Execute bubble requests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arm_hazard_detect
  import arm_pipeline_ctrl_pkg::*;
(
  input  logic [RegAddrWidth-1:0] i_ra_1d,
  input  logic [RegAddrWidth-1:0] i_ra_2d,
  input  logic [RegAddrWidth-1:0] i_wa_e,
  input  logic                    i_mem_to_reg_e,
  input  logic                    i_branch_taken_e,
  input  logic                    i_pc_src_d,
  input  logic                    i_pc_src_e,
  input  logic                    i_pc_src_m,
  input  logic                    i_pc_src_w,
  output logic                    o_stall_fetch,
  output logic                    o_stall_decode,
  output logic                    o_flush_decode,
  output logic                    o_flush_execute
);

  logic w_ld_stall;
  logic w_pc_pend;

  // A load in Execute feeding either Decode source cannot be forwarded in time.
  assign w_ld_stall = i_mem_to_reg_e & ((i_wa_e == i_ra_1d) | (i_wa_e == i_ra_2d));

  // An R15 write still in flight means the fetch address is not yet known.
  assign w_pc_pend  = i_pc_src_d | i_pc_src_e | i_pc_src_m;

  assign o_stall_fetch   = w_ld_stall | w_pc_pend;
  assign o_stall_decode  = w_ld_stall;
  assign o_flush_execute = w_ld_stall | i_branch_taken_e;
  assign o_flush_decode  = w_pc_pend | i_pc_src_w | i_branch_taken_e;

endmodule

`default_nettype wire

// File: rtl/arm_pipeline_stall_ctrl.sv
// ============================================================================
// Module      : arm_pipeline_stall_ctrl
// Description : Stall/flush sequencer for the 5-stage ARM pipeline. Merges
//               single-cycle hazards with freezes for a multi-cycle Execute
//               unit (with timeout) and a data memory ready handshake.
//               Optional macro STALL_PERF_COUNTER_EN enables the saturating
//               stall-cycle performance counter; otherwise it reads 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arm_pipeline_stall_ctrl
  import arm_pipeline_ctrl_pkg::*;
#(
  parameter int BusWidth   = 32,
  parameter int MC_TIMEOUT = 64
) (
  input  logic                    i_CLK,
  input  logic                    i_RESET,
  input  logic [RegAddrWidth-1:0] i_RegFile_RA_1D,
  input  logic [RegAddrWidth-1:0] i_RegFile_RA_2D,
  input  logic [RegAddrWidth-1:0] i_RegFile_WA_E,
  input  logic                    i_Mem_To_Reg_Execute,
  input  logic                    i_Branch_Taken_Execute,
  input  logic                    i_PC_Src_D,
  input  logic                    i_PC_Src_E,
  input  logic                    i_PC_Src_M,
  input  logic                    i_PC_Src_W,
  input  logic                    i_MC_Start_Execute,
  input  logic                    i_MC_Done,
  input  logic                    i_Mem_Req_Memory,
  input  logic                    i_Mem_Ready,
  output logic                    o_Stall_Fetch,
  output logic                    o_Stall_Decode,
  output logic                    o_Stall_Execute,
  output logic                    o_Stall_Memory,
  output logic                    o_Flush_Decode,
  output logic                    o_Flush_Execute,
  output logic                    o_Flush_Memory,
  output logic                    o_Flush_WriteBack,
  output logic                    o_MC_Timeout,
  output logic [1:0]              o_State,
  output logic [BusWidth-1:0]     o_Stall_Cycles
);

  localparam logic [1:0] c_ST_RUN      = RUN;
  localparam logic [1:0] c_ST_MC_BUSY  = MC_BUSY;
  localparam logic [1:0] c_ST_MEM_WAIT = MEM_WAIT;

  // Count value held on the last permitted multi-cycle stall cycle.
  localparam logic [7:0] c_MC_LAST = 8'(MC_TIMEOUT - 1);

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic [7:0] r_mc_count;
  logic [7:0] w_mc_count_next;

  logic w_hz_stall_fetch;
  logic w_hz_stall_decode;
  logic w_hz_flush_decode;
  logic w_hz_flush_execute;

  logic w_stall_fetch;
  logic w_stall_decode;
  logic w_stall_execute;
  logic w_stall_memory;
  logic w_flush_decode;
  logic w_flush_execute;
  logic w_flush_memory;
  logic w_flush_writeback;
  logic w_mc_timeout;

  arm_hazard_detect u_hazard (
    .i_ra_1d          (i_RegFile_RA_1D),
    .i_ra_2d          (i_RegFile_RA_2D),
    .i_wa_e           (i_RegFile_WA_E),
    .i_mem_to_reg_e   (i_Mem_To_Reg_Execute),
    .i_branch_taken_e (i_Branch_Taken_Execute),
    .i_pc_src_d       (i_PC_Src_D),
    .i_pc_src_e       (i_PC_Src_E),
    .i_pc_src_m       (i_PC_Src_M),
    .i_pc_src_w       (i_PC_Src_W),
    .o_stall_fetch    (w_hz_stall_fetch),
    .o_stall_decode   (w_hz_stall_decode),
    .o_flush_decode   (w_hz_flush_decode),
    .o_flush_execute  (w_hz_flush_execute)
  );

  // Next-state, MC counter and output selection; freezes override hazard terms.
  always_comb begin
    w_next_state      = r_state;
    w_mc_count_next   = r_mc_count;
    w_stall_fetch     = w_hz_stall_fetch;
    w_stall_decode    = w_hz_stall_decode;
    w_stall_execute   = 1'b0;
    w_stall_memory    = 1'b0;
    w_flush_decode    = w_hz_flush_decode;
    w_flush_execute   = w_hz_flush_execute;
    w_flush_memory    = 1'b0;
    w_flush_writeback = 1'b0;
    w_mc_timeout      = 1'b0;

    case (r_state)
      c_ST_RUN: begin
        w_mc_count_next = 8'd0;
        if (i_Mem_Req_Memory && !i_Mem_Ready) begin
          // Memory wait wins over a multi-cycle start; that op retries later.
          w_next_state      = c_ST_MEM_WAIT;
          w_stall_fetch     = 1'b1;
          w_stall_decode    = 1'b1;
          w_stall_execute   = 1'b1;
          w_stall_memory    = 1'b1;
          w_flush_decode    = 1'b0;
          w_flush_execute   = 1'b0;
          w_flush_writeback = 1'b1;
        end else if (i_MC_Start_Execute && !i_MC_Done) begin
          // The start cycle is already the first frozen cycle of the op.
          w_next_state    = c_ST_MC_BUSY;
          w_mc_count_next = 8'd1;
          w_stall_fetch   = 1'b1;
          w_stall_decode  = 1'b1;
          w_stall_execute = 1'b1;
          w_flush_decode  = 1'b0;
          w_flush_execute = 1'b0;
          w_flush_memory  = 1'b1;
        end
      end

      c_ST_MC_BUSY: begin
        if (i_MC_Done) begin
          w_next_state    = c_ST_RUN;
          w_mc_count_next = 8'd0;
        end else begin
          w_stall_fetch   = 1'b1;
          w_stall_decode  = 1'b1;
          w_stall_execute = 1'b1;
          w_flush_decode  = 1'b0;
          w_flush_execute = 1'b0;
          w_flush_memory  = 1'b1;
          if (r_mc_count == c_MC_LAST) begin
            w_mc_timeout    = 1'b1;
            w_next_state    = c_ST_RUN;
            w_mc_count_next = 8'd0;
          end else begin
            w_mc_count_next = r_mc_count + 8'd1;
          end
        end
      end

      c_ST_MEM_WAIT: begin
        if (i_Mem_Ready) begin
          w_next_state = c_ST_RUN;
        end else begin
          w_stall_fetch     = 1'b1;
          w_stall_decode    = 1'b1;
          w_stall_execute   = 1'b1;
          w_stall_memory    = 1'b1;
          w_flush_decode    = 1'b0;
          w_flush_execute   = 1'b0;
          w_flush_writeback = 1'b1;
        end
      end

      default: begin
        w_next_state    = c_ST_RUN;
        w_mc_count_next = 8'd0;
      end
    endcase
  end

  // State and multi-cycle counter registers.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      r_state    <= c_ST_RUN;
      r_mc_count <= 8'd0;
    end else begin
      r_state    <= w_next_state;
      r_mc_count <= w_mc_count_next;
    end
  end

  // Reset silences every control output immediately, not only after the edge.
  assign o_Stall_Fetch     = ~i_RESET & w_stall_fetch;
  assign o_Stall_Decode    = ~i_RESET & w_stall_decode;
  assign o_Stall_Execute   = ~i_RESET & w_stall_execute;
  assign o_Stall_Memory    = ~i_RESET & w_stall_memory;
  assign o_Flush_Decode    = ~i_RESET & w_flush_decode;
  assign o_Flush_Execute   = ~i_RESET & w_flush_execute;
  assign o_Flush_Memory    = ~i_RESET & w_flush_memory;
  assign o_Flush_WriteBack = ~i_RESET & w_flush_writeback;
  assign o_MC_Timeout      = ~i_RESET & w_mc_timeout;
  assign o_State           = r_state;

`ifdef STALL_PERF_COUNTER_EN
  logic [BusWidth-1:0] r_stall_cycles;

  // Saturating count of cycles in which Fetch was held.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      r_stall_cycles <= '0;
    end else if (o_Stall_Fetch && (r_stall_cycles != {BusWidth{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + {{(BusWidth-1){1'b0}}, 1'b1};
    end
  end

  assign o_Stall_Cycles = r_stall_cycles;
`else
  assign o_Stall_Cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_arm_pipeline_stall_ctrl.sv
// ============================================================================
// Module      : tb_arm_pipeline_stall_ctrl
// Description : Self-checking bench for arm_pipeline_stall_ctrl: directed
//               scenarios followed by random traffic, all compared against a
//               behavioural model of the pipeline's freeze/hazard rules.
//               Honours STALL_PERF_COUNTER_EN for the counter expectation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arm_pipeline_stall_ctrl;

  localparam int BW  = 32;
  localparam int MCT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ra1, ra2, wa;
  logic        mte, bt, pcd, pce, pcm, pcw, start, done, req, ready;
  logic        sf, sd, se, sm, fd, fe, fm, fwb, to;
  logic [1:0]  state;
  logic [BW-1:0] cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Abstract model: how many cycles the current multi-cycle op has frozen
  // the pipeline (0 = none in progress), whether a memory access is pending,
  // and the total number of Fetch-stall cycles seen since reset.
  int      m_mc_frozen;
  bit      m_mem_pending;
  longint  m_stalls;

  always #5 clk = ~clk;

  arm_pipeline_stall_ctrl #(.BusWidth(BW), .MC_TIMEOUT(MCT)) dut (
    .i_CLK                  (clk),
    .i_RESET                (rst),
    .i_RegFile_RA_1D        (ra1),
    .i_RegFile_RA_2D        (ra2),
    .i_RegFile_WA_E         (wa),
    .i_Mem_To_Reg_Execute   (mte),
    .i_Branch_Taken_Execute (bt),
    .i_PC_Src_D             (pcd),
    .i_PC_Src_E             (pce),
    .i_PC_Src_M             (pcm),
    .i_PC_Src_W             (pcw),
    .i_MC_Start_Execute     (start),
    .i_MC_Done              (done),
    .i_Mem_Req_Memory       (req),
    .i_Mem_Ready            (ready),
    .o_Stall_Fetch          (sf),
    .o_Stall_Decode         (sd),
    .o_Stall_Execute        (se),
    .o_Stall_Memory         (sm),
    .o_Flush_Decode         (fd),
    .o_Flush_Execute        (fe),
    .o_Flush_Memory         (fm),
    .o_Flush_WriteBack      (fwb),
    .o_MC_Timeout           (to),
    .o_State                (state),
    .o_Stall_Cycles         (cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    rst = 1'b0; ra1 = 4'd0; ra2 = 4'd0; wa = 4'd0;
    mte = 1'b0; bt = 1'b0; pcd = 1'b0; pce = 1'b0; pcm = 1'b0; pcw = 1'b0;
    start = 1'b0; done = 1'b0; req = 1'b0; ready = 1'b0;
  endtask

  // One clock cycle with the inputs currently driven: predict, compare, advance.
  // Output vector order: SF SD SE SM FD FE FM FWB TO.
  task automatic cycle(input string tag);
    logic [8:0]  exp_o, hz, mc_frz, mem_frz;
    logic [1:0]  exp_st;
    logic [63:0] exp_cnt;
    logic        ld, pp;
    @(negedge clk);
    ld      = mte && ((wa == ra1) || (wa == ra2));
    pp      = pcd || pce || pcm;
    hz      = {ld | pp, ld, 1'b0, 1'b0, pp | pcw | bt, ld | bt, 1'b0, 1'b0, 1'b0};
    mc_frz  = 9'b1110_0010_0;
    mem_frz = 9'b1111_0001_0;
    exp_st  = m_mem_pending ? 2'd2 : (m_mc_frozen > 0) ? 2'd1 : 2'd0;
`ifdef STALL_PERF_COUNTER_EN
    exp_cnt = 64'(m_stalls);
`else
    exp_cnt = 64'd0;
`endif
    if (rst) begin
      exp_o = 9'd0;
    end else if (m_mem_pending) begin
      exp_o = ready ? hz : mem_frz;
    end else if (m_mc_frozen > 0) begin
      exp_o = done ? hz : mc_frz;
      if (!done && (m_mc_frozen + 1 == MCT)) exp_o[0] = 1'b1;
    end else if (req && !ready) begin
      exp_o = mem_frz;
    end else if (start && !done) begin
      exp_o = mc_frz;
    end else begin
      exp_o = hz;
    end

    check({tag, ".outs"}, 64'({sf, sd, se, sm, fd, fe, fm, fwb, to}), 64'(exp_o));
    check({tag, ".state"}, 64'(state), 64'(exp_st));
    check({tag, ".cnt"}, 64'(cnt), exp_cnt);

    // Advance the model to what the next cycle should look like.
    if (rst) begin
      m_mc_frozen = 0; m_mem_pending = 1'b0; m_stalls = 0;
    end else begin
      if (exp_o[8] && m_stalls < 64'hFFFF_FFFF) m_stalls++;
      if (m_mem_pending) begin
        if (ready) m_mem_pending = 1'b0;
      end else if (m_mc_frozen > 0) begin
        if (done || exp_o[0]) m_mc_frozen = 0;
        else m_mc_frozen++;
      end else if (req && !ready) begin
        m_mem_pending = 1'b1;
      end else if (start && !done) begin
        m_mc_frozen = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    m_mc_frozen = 0; m_mem_pending = 1'b0; m_stalls = 0;
    @(posedge clk);
    #1;
    cycle("reset0");
    cycle("reset1");
    rst = 1'b0;

    // Load-use on RA_1D, then cleared, then non-matching sources.
    mte = 1'b1; wa = 4'd3; ra1 = 4'd3; ra2 = 4'd9;
    cycle("ld_use");
    mte = 1'b0;
    cycle("ld_after");
    mte = 1'b1; ra1 = 4'd5; ra2 = 4'd6;
    cycle("ld_nomatch");
    mte = 1'b0;

    // Branch taken, then an R15 write walking down the pipe.
    bt = 1'b1;  cycle("branch");
    bt = 1'b0;
    pcd = 1'b1; cycle("pc_d");
    pcd = 1'b0; pce = 1'b1; cycle("pc_e");
    pce = 1'b0; pcm = 1'b1; cycle("pc_m");
    pcm = 1'b0; pcw = 1'b1; cycle("pc_w");
    pcw = 1'b0; cycle("pc_done");

    // Multi-cycle op with done five cycles after start.
    start = 1'b1;
    for (int i = 0; i < 5; i++) cycle("mc_busy");
    done = 1'b1; cycle("mc_done");
    start = 1'b0; done = 1'b0; cycle("mc_idle");
    start = 1'b1; done = 1'b1; cycle("mc_single");
    done = 1'b0;

    // Done never arrives: forced exit on the MCT-th frozen cycle.
    for (int i = 0; i < MCT; i++) cycle("mc_timeout");
    start = 1'b0; cycle("mc_after_to");

    // Memory wait with a concurrent multi-cycle start, then release.
    req = 1'b1; ready = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) cycle("mem_wait");
    ready = 1'b1; cycle("mem_ready");
    req = 1'b0; ready = 1'b0; cycle("mc_after_mem");
    cycle("mc_after_mem2");
    done = 1'b1; cycle("mc_after_mem_done");
    start = 1'b0; done = 1'b0;

    // Reset in the middle of a multi-cycle op.
    start = 1'b1;
    cycle("mc_pre_rst0");
    cycle("mc_pre_rst1");
    rst = 1'b1; cycle("mc_rst");
    rst = 1'b0; start = 1'b0; cycle("mc_post_rst");

    // Reset in the middle of a memory wait.
    req = 1'b1; cycle("mem_pre_rst");
    rst = 1'b1; cycle("mem_rst");
    rst = 1'b0; req = 1'b0; cycle("mem_post_rst");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 79) == 0);
      ra1   = 4'($urandom_range(0, 15));
      ra2   = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: wa = ra1;
        1: wa = ra2;
        default: wa = 4'($urandom_range(0, 15));
      endcase
      mte   = ($urandom_range(0, 2) == 0);
      bt    = ($urandom_range(0, 7) == 0);
      pcd   = ($urandom_range(0, 7) == 0);
      pce   = ($urandom_range(0, 7) == 0);
      pcm   = ($urandom_range(0, 7) == 0);
      pcw   = ($urandom_range(0, 7) == 0);
      start = ($urandom_range(0, 3) == 0);
      done  = ($urandom_range(0, 9) == 0);
      req   = ($urandom_range(0, 4) == 0);
      ready = ($urandom_range(0, 1) == 0);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
